alu_ctrl_decode: RTL and testbench

ALU_CTRL_DECODE -- requirements
Module: alu_ctrl_decode

---
 rtl/alu_ctrl_decode.sv | 103 ++++++++++
 tb/tb_alu_ctrl_decode.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: one-stage registered RV32I ALU control decoder with valid/ready handshake
module alu_ctrl_decode #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       alu_control,
    output logic [31:0]      imm,
    output logic             use_imm,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             reg_write,
    output logic             is_branch,
    output logic             illegal,
    output logic [CNT_W-1:0] dec_count
);
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [5:0] r_alu, d_alu;
    logic [31:0] imm_i, imm_sh, imm_b, d_imm;
    logic d_ill, d_use_imm, d_reg_write, d_branch;
    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_sh = {27'b0, instr[24:20]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign in_ready = !out_valid || out_ready;
    always_comb begin
        r_alu = f3 == 3'd0 ? 6'd1 :
                f3 == 3'd1 ? 6'd3 :
                f3 == 3'd2 ? 6'd4 :
                f3 == 3'd3 ? 6'd5 :
                f3 == 3'd4 ? 6'd6 :
                f3 == 3'd5 ? 6'd7 :
                f3 == 3'd6 ? 6'd9 : 6'd10;
    end
    always_comb begin
        d_ill = 1'b1;
        d_alu = '0;
        d_imm = '0;
        case (op)
            OP_R: begin
                d_ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                d_alu = f7 == 7'h20 ? (f3 == 3'd0 ? 6'd2 : 6'd8) : r_alu;
            end
            OP_I: begin
                d_ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
                d_alu = (f3 == 3'd5 && f7 == 7'h20) ? 6'd19 : 6'd11 + 6'(f3);
                d_imm = (f3 == 3'd1 || f3 == 3'd5) ? imm_sh : imm_i;
            end
            OP_B: begin
                d_ill = f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
                d_alu = f3 == 3'd0 ? 6'd27 : f3 == 3'd1 ? 6'd28 : f3 == 3'd4 ? 6'd32 : 6'd31;
                d_imm = imm_b;
            end
            default: ;
        endcase
        d_use_imm = !d_ill && op == OP_I;
        d_reg_write = !d_ill && (op == OP_R || op == OP_I);
        d_branch = !d_ill && op == OP_B;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_control <= '0;
            imm <= '0;
            use_imm <= 1'b0;
            rs1 <= '0;
            rs2 <= '0;
            rd <= '0;
            reg_write <= 1'b0;
            is_branch <= 1'b0;
            illegal <= 1'b0;
            dec_count <= '0;
        end else begin
            if (in_valid && in_ready) begin
                out_valid <= 1'b1;
                alu_control <= d_ill ? 6'd0 : d_alu;
                imm <= d_ill ? 32'd0 : d_imm;
                use_imm <= d_use_imm;
                rs1 <= instr[19:15];
                rs2 <= instr[24:20];
                rd <= instr[11:7];
                reg_write <= d_reg_write;
                is_branch <= d_branch;
                illegal <= d_ill;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) dec_count <= dec_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_ctrl_decode.sv
// tb_alu_ctrl_decode: directed-vector self-checking bench for alu_ctrl_decode
module tb_alu_ctrl_decode;
    logic clk = 1'b0;
    logic rst, in_valid, out_ready, in_ready, out_valid;
    logic [31:0] instr, imm;
    logic [5:0] alu_control;
    logic use_imm, reg_write, is_branch, illegal;
    logic [4:0] rs1, rs2, rd;
    logic [15:0] dec_count;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    alu_ctrl_decode #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control), .imm(imm),
        .use_imm(use_imm), .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write),
        .is_branch(is_branch), .illegal(illegal), .dec_count(dec_count)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [31:0] w);
        instr = w;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        instr = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (dec_count !== 16'd0) begin n_bad++; $display("FAIL reset_dec_count got %0d want 0", dec_count); end
        n_cmp++; if ({alu_control, imm, use_imm, reg_write, is_branch, illegal, rs1, rs2, rd} !== '0) begin
            n_bad++; $display("FAIL reset_fields got alu=%0d imm=%h ill=%b want all zero", alu_control, imm, illegal); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask
    task automatic test_add;
        instr = 32'h002081B3;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid got %b want 1", out_valid); end
        n_cmp++; if (alu_control !== 6'd1) begin n_bad++; $display("FAIL add_alu got %0d want 1", alu_control); end
        n_cmp++; if ({rs1, rs2, rd} !== {5'd1, 5'd2, 5'd3}) begin
            n_bad++; $display("FAIL add_regs got %0d/%0d/%0d want 1/2/3", rs1, rs2, rd); end
        n_cmp++; if ({reg_write, use_imm, is_branch, illegal} !== 4'b1000) begin
            n_bad++; $display("FAIL add_flags got %b want 1000", {reg_write, use_imm, is_branch, illegal}); end
        n_cmp++; if (imm !== 32'd0) begin n_bad++; $display("FAIL add_imm got %h want 0", imm); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_drain got %b want 0", out_valid); end
        n_cmp++; if (dec_count !== 16'd1) begin n_bad++; $display("FAIL add_count got %0d want 1", dec_count); end
    endtask
    task automatic test_back_to_back;
        logic [15:0] c0;
        c0 = dec_count;
        out_ready = 1'b1;
        in_valid = 1'b1;
        instr = 32'h402081B3;
        tick();
        instr = 32'hFFF00293;
        n_cmp++; if (out_valid !== 1'b1 || alu_control !== 6'd2) begin
            n_bad++; $display("FAIL b2b_sub got v=%b alu=%0d want v=1 alu=2", out_valid, alu_control); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || alu_control !== 6'd11) begin
            n_bad++; $display("FAIL b2b_addi got v=%b alu=%0d want v=1 alu=11", out_valid, alu_control); end
        n_cmp++; if (imm !== 32'hFFFFFFFF || use_imm !== 1'b1 || rd !== 5'd5) begin
            n_bad++; $display("FAIL b2b_addi_imm got imm=%h ui=%b rd=%0d want FFFFFFFF 1 5", imm, use_imm, rd); end
        tick();
        n_cmp++; if (dec_count !== c0 + 16'd2) begin
            n_bad++; $display("FAIL b2b_count got %0d want %0d", dec_count, c0 + 16'd2); end
    endtask
    task automatic test_shift_branch;
        send(32'h4033D313);
        n_cmp++; if (alu_control !== 6'd19 || imm !== 32'd3 || rs1 !== 5'd7 || rd !== 5'd6 || use_imm !== 1'b1) begin
            n_bad++; $display("FAIL srai got alu=%0d imm=%h rs1=%0d rd=%0d ui=%b want 19 3 7 6 1", alu_control, imm, rs1, rd, use_imm); end
        send(32'hFE208EE3);
        n_cmp++; if (alu_control !== 6'd27 || imm !== 32'hFFFFFFFC) begin
            n_bad++; $display("FAIL beq got alu=%0d imm=%h want 27 FFFFFFFC", alu_control, imm); end
        n_cmp++; if ({is_branch, reg_write, use_imm, illegal} !== 4'b1000) begin
            n_bad++; $display("FAIL beq_flags got %b want 1000", {is_branch, reg_write, use_imm, illegal}); end
        tick();
    endtask
    task automatic test_table;
        logic [5:0] r_exp [8] = '{6'd1, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10};
        logic [5:0] b_exp [8] = '{6'd27, 6'd28, 6'd0, 6'd0, 6'd32, 6'd31, 6'd0, 6'd0};
        for (int i = 0; i < 8; i++) begin
            send({7'h00, 5'd2, 5'd1, 3'(i), 5'd3, 7'b0110011});
            n_cmp++; if (alu_control !== r_exp[i] || {illegal, reg_write, use_imm, is_branch} !== 4'b0100) begin
                n_bad++; $display("FAIL rtype_f3_%0d got alu=%0d flags=%b want %0d 0100", i, alu_control, {illegal, reg_write, use_imm, is_branch}, r_exp[i]); end
            send({7'h00, 5'd2, 5'd1, 3'(i), 5'd3, 7'b0010011});
            n_cmp++; if (alu_control !== 6'd11 + 6'(i) || imm !== 32'd2 || {illegal, reg_write, use_imm, is_branch} !== 4'b0110) begin
                n_bad++; $display("FAIL itype_f3_%0d got alu=%0d imm=%h flags=%b want %0d 2 0110", i, alu_control, imm, {illegal, reg_write, use_imm, is_branch}, 11 + i); end
            send({7'h00, 5'd2, 5'd1, 3'(i), 5'd3, 7'b1100011});
            n_cmp++; if (alu_control !== b_exp[i] || illegal !== (b_exp[i] == 6'd0) || is_branch !== (b_exp[i] != 6'd0)
                         || reg_write !== 1'b0 || use_imm !== 1'b0 || imm !== (b_exp[i] == 6'd0 ? 32'd0 : 32'h802)) begin
                n_bad++; $display("FAIL branch_f3_%0d got alu=%0d ill=%b br=%b imm=%h want alu=%0d", i, alu_control, illegal, is_branch, imm, b_exp[i]); end
        end
        send({7'h20, 5'd2, 5'd1, 3'd5, 5'd3, 7'b0110011});
        n_cmp++; if (alu_control !== 6'd8 || illegal !== 1'b0) begin
            n_bad++; $display("FAIL sra got alu=%0d ill=%b want 8 0", alu_control, illegal); end
        send({7'h20, 5'd2, 5'd1, 3'd1, 5'd3, 7'b0110011});
        n_cmp++; if (illegal !== 1'b1 || alu_control !== 6'd0 || reg_write !== 1'b0) begin
            n_bad++; $display("FAIL r_f7_bad got ill=%b alu=%0d rw=%b want 1 0 0", illegal, alu_control, reg_write); end
        send({7'h20, 5'd2, 5'd1, 3'd1, 5'd3, 7'b0010011});
        n_cmp++; if (illegal !== 1'b1 || alu_control !== 6'd0 || use_imm !== 1'b0) begin
            n_bad++; $display("FAIL slli_f7_bad got ill=%b alu=%0d ui=%b want 1 0 0", illegal, alu_control, use_imm); end
        send({7'h01, 5'd2, 5'd1, 3'd5, 5'd3, 7'b0010011});
        n_cmp++; if (illegal !== 1'b1 || alu_control !== 6'd0) begin
            n_bad++; $display("FAIL srli_f7_bad got ill=%b alu=%0d want 1 0", illegal, alu_control); end
        tick();
    endtask
    task automatic test_backpressure;
        logic [15:0] c0;
        c0 = dec_count;
        instr = 32'h002081B3;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        instr = 32'hFFF00293;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_control !== 6'd1 || rd !== 5'd3 || dec_count !== c0) begin
                n_bad++; $display("FAIL stall_%0d got rdy=%b v=%b alu=%0d rd=%0d cnt=%0d want 0 1 1 3 %0d", i, in_ready, out_valid, alu_control, rd, dec_count, c0); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || alu_control !== 6'd11 || dec_count !== c0 + 16'd1) begin
            n_bad++; $display("FAIL stall_next got v=%b alu=%0d cnt=%0d want 1 11 %0d", out_valid, alu_control, dec_count, c0 + 16'd1); end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || dec_count !== c0 + 16'd2) begin
            n_bad++; $display("FAIL stall_drain got v=%b cnt=%0d want 0 %0d", out_valid, dec_count, c0 + 16'd2); end
    endtask
    task automatic test_illegal;
        logic [15:0] c0;
        c0 = dec_count;
        send(32'hFFFFFFFF);
        n_cmp++; if (illegal !== 1'b1 || alu_control !== 6'd0 || {reg_write, is_branch, use_imm} !== 3'b000) begin
            n_bad++; $display("FAIL ill_ones got ill=%b alu=%0d flags=%b want 1 0 000", illegal, alu_control, {reg_write, is_branch, use_imm}); end
        send(32'h0020E063);
        n_cmp++; if (illegal !== 1'b1 || alu_control !== 6'd0 || {reg_write, is_branch, use_imm} !== 3'b000) begin
            n_bad++; $display("FAIL ill_bltu got ill=%b alu=%0d flags=%b want 1 0 000", illegal, alu_control, {reg_write, is_branch, use_imm}); end
        tick();
        n_cmp++; if (dec_count !== c0 + 16'd2) begin
            n_bad++; $display("FAIL ill_count got %0d want %0d", dec_count, c0 + 16'd2); end
    endtask
    task automatic test_reset_stall;
        instr = 32'h002081B3;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || dec_count === 16'd0) begin
            n_bad++; $display("FAIL rst_stall_pre got v=%b cnt=%0d want 1 nonzero", out_valid, dec_count); end
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || dec_count !== 16'd0 || in_ready !== 1'b1 || alu_control !== 6'd0 || rd !== 5'd0) begin
            n_bad++; $display("FAIL rst_stall got v=%b cnt=%0d rdy=%b alu=%0d rd=%0d want 0 0 1 0 0", out_valid, dec_count, in_ready, alu_control, rd); end
    endtask
    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_shift_branch();
        test_table();
        test_backpressure();
        test_illegal();
        test_reset_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
